// File: rtl/stream_upsampler_pkg.sv
// ============================================================================
// Module   : stream_upsampler_pkg
// Brief    : Shared helpers for the 2x nearest-neighbour stream upsampler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_upsampler_pkg;

    // Ceiling log2, never narrower than one bit so derived vectors stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int pixel_word_bits(input int bit_width, input int units);
        return bit_width * units;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer_sdp.sv
// ============================================================================
// Module   : line_buffer_sdp
// Brief    : Simple dual-port row buffer; resettable valid column, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_sdp
    import stream_upsampler_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_data_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid_mem;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Data array carries no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en && wr_data_en) begin
            r_data_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_data_mem[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_valid_mem <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                r_valid_mem[wr_addr] <= wr_valid;
            end
            if (rd_en) begin
                r_rd_valid <= r_valid_mem[rd_addr];
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/stream_upsampler.sv
// ============================================================================
// Module   : stream_upsampler
// Brief    : 2x nearest-neighbour upsampler, one-row line buffer, 2-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_upsampler
    import stream_upsampler_pkg::*;
#(
    parameter  int BIT_WIDTH = 8,
    parameter  int UNITS     = 1,
    parameter  int WIDTH     = 64,
    parameter  int HEIGHT    = 64,
    parameter  int W_WIDTH   = 80,
    parameter  int W_HEIGHT  = 70,
    localparam int H_BITW    = clog2(W_WIDTH),
    localparam int V_BITW    = clog2(W_HEIGHT),
    localparam int PIX_W     = pixel_word_bits(BIT_WIDTH, UNITS)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_enable,
    input  logic [PIX_W-1:0]  in_pixels,
    input  logic [V_BITW-1:0] in_vcnt,
    input  logic [H_BITW-1:0] in_hcnt,
    output logic              out_enable,
    output logic [PIX_W-1:0]  out_pixels,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt
);

    localparam int LB_DEPTH  = WIDTH / 2;
    localparam int LB_ADDR_W = clog2(LB_DEPTH);
    localparam int LATENCY   = 2;

    if ((WIDTH % 2) != 0) begin : g_chk_width_even
        $error("stream_upsampler: WIDTH must be even");
    end
    if ((HEIGHT % 2) != 0) begin : g_chk_height_even
        $error("stream_upsampler: HEIGHT must be even");
    end
    if (W_WIDTH < WIDTH) begin : g_chk_w_width
        $error("stream_upsampler: W_WIDTH must be >= WIDTH");
    end
    if (W_HEIGHT < HEIGHT) begin : g_chk_w_height
        $error("stream_upsampler: W_HEIGHT must be >= HEIGHT");
    end
    if (LATENCY != 2) begin : g_chk_latency
        $error("stream_upsampler: pipeline is built for LATENCY == 2");
    end

    logic                 w_in_image;
    logic                 w_even_row;
    logic                 w_even_col;
    logic                 w_accept;
    logic                 w_lb_wr_en;
    logic                 w_lb_rd_en;
    logic [LB_ADDR_W-1:0] w_lb_addr;
    logic                 w_lb_rd_valid;
    logic [PIX_W-1:0]     w_lb_rd_data;

    logic [V_BITW-1:0]    r_s1_vcnt;
    logic [H_BITW-1:0]    r_s1_hcnt;
    logic [PIX_W-1:0]     r_hold;
    logic                 r_hold_valid;

    logic                 w_s1_in_image;
    logic                 w_out_enable;
    logic [PIX_W-1:0]     w_out_pixels;

    logic                 r_out_enable;
    logic [PIX_W-1:0]     r_out_pixels;
    logic [V_BITW-1:0]    r_out_vcnt;
    logic [H_BITW-1:0]    r_out_hcnt;

    // Compare one bit wider so an image edge equal to 2**BITW does not wrap.
    assign w_in_image = ({1'b0, in_vcnt} < (V_BITW+1)'(HEIGHT))
                     && ({1'b0, in_hcnt} < (H_BITW+1)'(WIDTH));
    assign w_even_row = ~in_vcnt[0];
    assign w_even_col = ~in_hcnt[0];
    assign w_accept   = in_enable && w_even_row && w_even_col && w_in_image;
    assign w_lb_wr_en = w_even_row && w_even_col && w_in_image;
    assign w_lb_rd_en = ~w_even_row && w_in_image;
    assign w_lb_addr  = LB_ADDR_W'(in_hcnt >> 1);

    line_buffer_sdp #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (PIX_W),
        .ADDR_W (LB_ADDR_W)
    ) u_line_buffer (
        .clock      (clock),
        .rst        (rst),
        .wr_en      (w_lb_wr_en),
        .wr_data_en (w_accept),
        .wr_addr    (w_lb_addr),
        .wr_valid   (w_accept),
        .wr_data    (in_pixels),
        .rd_en      (w_lb_rd_en),
        .rd_addr    (w_lb_addr),
        .rd_valid   (w_lb_rd_valid),
        .rd_data    (w_lb_rd_data)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_s1_vcnt    <= '0;
            r_s1_hcnt    <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_s1_vcnt <= in_vcnt;
            r_s1_hcnt <= in_hcnt;
            if (w_accept) begin
                r_hold       <= in_pixels;
                r_hold_valid <= 1'b1;
            end else if (w_even_col && w_in_image) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Even rows replay the held pixel; odd rows replay the row above.
    always_comb begin
        w_s1_in_image = ({1'b0, r_s1_vcnt} < (V_BITW+1)'(HEIGHT))
                     && ({1'b0, r_s1_hcnt} < (H_BITW+1)'(WIDTH));
        w_out_enable  = 1'b0;
        w_out_pixels  = '0;
        if (w_s1_in_image) begin
            if (r_s1_vcnt[0]) begin
                w_out_enable = w_lb_rd_valid;
                w_out_pixels = w_lb_rd_data;
            end else begin
                w_out_enable = r_hold_valid;
                w_out_pixels = r_hold;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_out_enable <= 1'b0;
            r_out_pixels <= '0;
            r_out_vcnt   <= '0;
            r_out_hcnt   <= '0;
        end else begin
            r_out_enable <= w_out_enable;
            r_out_pixels <= w_out_pixels;
            r_out_vcnt   <= r_s1_vcnt;
            r_out_hcnt   <= r_s1_hcnt;
        end
    end

    assign out_enable = r_out_enable;
    assign out_pixels = r_out_pixels;
    assign out_vcnt   = r_out_vcnt;
    assign out_hcnt   = r_out_hcnt;

endmodule

`default_nettype wire

// File: tb/tb_stream_upsampler.sv
// ============================================================================
// Module   : tb_stream_upsampler
// Brief    : Table-driven self-checking bench for stream_upsampler (8x8 image).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_upsampler;

    localparam int BIT_WIDTH = 8;
    localparam int UNITS     = 2;
    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 8;
    localparam int W_WIDTH   = 10;
    localparam int W_HEIGHT  = 10;
    localparam int PW        = BIT_WIDTH * UNITS;
    localparam int VB        = 4;
    localparam int HB        = 4;
    localparam int MAX_VEC   = 800;

    logic          clock     = 1'b0;
    logic          rst       = 1'b1;
    logic          in_enable = 1'b0;
    logic [PW-1:0] in_pixels = '0;
    logic [VB-1:0] in_vcnt   = '0;
    logic [HB-1:0] in_hcnt   = '0;
    logic          out_enable;
    logic [PW-1:0] out_pixels;
    logic [VB-1:0] out_vcnt;
    logic [HB-1:0] out_hcnt;

    stream_upsampler #(
        .BIT_WIDTH (BIT_WIDTH),
        .UNITS     (UNITS),
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .W_WIDTH   (W_WIDTH),
        .W_HEIGHT  (W_HEIGHT)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .in_enable  (in_enable),
        .in_pixels  (in_pixels),
        .in_vcnt    (in_vcnt),
        .in_hcnt    (in_hcnt),
        .out_enable (out_enable),
        .out_pixels (out_pixels),
        .out_vcnt   (out_vcnt),
        .out_hcnt   (out_hcnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          en;
        logic [PW-1:0] pix;
        int            v;
        int            h;
        int            frame;
        logic          exp_en;
        logic          chk_pix;
        logic [PW-1:0] exp_pix;
    } vec_t;

    vec_t          vecs [MAX_VEC];
    int            n_vec = 0;
    int            total = 0;
    int            bad   = 0;
    logic          drop_in   [4][4];
    logic          drop_even [4][4];
    logic          drop_odd  [4][4];
    logic          got_en    [8][8][8];
    logic [PW-1:0] got_pix   [8][8][8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_drops();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                drop_in[y][x]   = 1'b0;
                drop_even[y][x] = 1'b0;
                drop_odd[y][x]  = 1'b0;
            end
        end
    endtask

    task automatic add_idle(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            vecs[n_vec] = '{rst: r, en: 1'b0, pix: '0, v: 0, h: 0, frame: -1,
                            exp_en: 1'b0, chk_pix: 1'b0, exp_pix: '0};
            n_vec++;
        end
    endtask

    // Source (2y,2x) carries offset+16*y+x on both channels; garbage drives 0xFF elsewhere.
    task automatic add_frame(input int frame, input int rows, input logic [7:0] offset,
                             input bit garbage, input int rst_row);
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h < W_WIDTH; h++) begin
                vec_t       r;
                logic [7:0] val;
                bit         img;
                bit         ev;
                img     = (v < HEIGHT) && (h < WIDTH);
                ev      = (v % 2 == 0) && (h % 2 == 0);
                val     = 8'(offset + 16 * (v / 2) + (h / 2));
                r.v     = v;
                r.h     = h;
                r.frame = frame;
                r.rst   = (v == rst_row) && (h == 3 || h == 4);
                r.en    = 1'b0;
                r.pix   = '0;
                if (img && ev) begin
                    if (!drop_in[v/2][h/2]) begin
                        r.en  = 1'b1;
                        r.pix = {val, val};
                    end
                end else if (garbage) begin
                    r.en  = 1'b1;
                    r.pix = '1;
                end
                r.exp_en  = 1'b0;
                r.chk_pix = 1'b1;
                r.exp_pix = '0;
                if (img) begin
                    r.exp_en  = (v % 2 == 0) ? !drop_even[v/2][h/2] : !drop_odd[v/2][h/2];
                    r.chk_pix = r.exp_en;
                    r.exp_pix = {val, val};
                end
                vecs[n_vec] = r;
                n_vec++;
            end
        end
    endtask

    initial begin
        clear_drops();
        add_idle(3, 1'b1);
        add_frame(0, W_HEIGHT, 8'h00, 1'b0, -1);
        drop_in[1][2] = 1'b1;
        drop_even[1][2] = 1'b1;
        drop_odd[1][2]  = 1'b1;
        add_frame(1, W_HEIGHT, 8'h00, 1'b0, -1);
        clear_drops();
        add_frame(2, W_HEIGHT, 8'h00, 1'b1, -1);
        add_frame(3, HEIGHT, 8'h00, 1'b0, -1);
        add_frame(4, HEIGHT, 8'h40, 1'b0, -1);
        // Reset at (4,3)-(4,4): source (2,2) lost; row 5 cols 0..5 lose their cleared valids.
        drop_even[2][2] = 1'b1;
        for (int x = 0; x < 3; x++) drop_odd[2][x] = 1'b1;
        add_frame(5, W_HEIGHT, 8'h00, 1'b0, 4);
        clear_drops();
        add_frame(6, W_HEIGHT, 8'h00, 1'b0, -1);
        add_idle(2, 1'b0);

        for (int j = 0; j < n_vec; j++) begin
            @(posedge clock);
            #1;
            rst       = vecs[j].rst;
            in_enable = vecs[j].en;
            in_pixels = vecs[j].pix;
            in_vcnt   = VB'(vecs[j].v);
            in_hcnt   = HB'(vecs[j].h);
            @(negedge clock);
            if (j >= 2) begin
                vec_t  s;
                string tag;
                s   = vecs[j-2];
                tag = $sformatf("frame=%0d y=%0d x=%0d", s.frame, s.v, s.h);
                if (vecs[j-1].rst || vecs[j-2].rst) begin
                    check({"reset_enable ", tag}, 32'(out_enable), 32'(0));
                    check({"reset_pixels ", tag}, 32'(out_pixels), 32'(0));
                    check({"reset_vcnt ", tag}, 32'(out_vcnt), 32'(0));
                    check({"reset_hcnt ", tag}, 32'(out_hcnt), 32'(0));
                end else begin
                    check({"enable ", tag}, 32'(out_enable), 32'(s.exp_en));
                    if (s.chk_pix) check({"pixels ", tag}, 32'(out_pixels), 32'(s.exp_pix));
                    check({"vcnt ", tag}, 32'(out_vcnt), 32'(s.v));
                    check({"hcnt ", tag}, 32'(out_hcnt), 32'(s.h));
                    if (s.frame >= 0 && s.v < HEIGHT && s.h < WIDTH) begin
                        got_en[s.frame][s.v][s.h]  = out_enable;
                        got_pix[s.frame][s.v][s.h] = out_pixels;
                    end
                end
            end
        end

        // Missing source (2,4): its 2x2 block is invalid, neighbours intact.
        check("drop_2_4_en", 32'(got_en[1][2][4]), 32'(0));
        check("drop_2_5_en", 32'(got_en[1][2][5]), 32'(0));
        check("drop_3_4_en", 32'(got_en[1][3][4]), 32'(0));
        check("drop_3_5_en", 32'(got_en[1][3][5]), 32'(0));
        check("drop_2_6_en", 32'(got_en[1][2][6]), 32'(1));
        check("drop_2_6_pix", 32'(got_pix[1][2][6]), 32'h1313);
        check("drop_3_6_pix", 32'(got_pix[1][3][6]), 32'h1313);
        check("drop_2_3_pix", 32'(got_pix[1][2][3]), 32'h1111);
        // Back-to-back frame: rows 0/1 carry the new frame's row 0.
        check("b2b_0_0_pix", 32'(got_pix[4][0][0]), 32'h4040);
        check("b2b_1_7_pix", 32'(got_pix[4][1][7]), 32'h4343);
        // Mid-frame reset recovery.
        check("rst_4_1_pix", 32'(got_pix[5][4][1]), 32'h2020);
        check("rst_4_5_en", 32'(got_en[5][4][5]), 32'(0));
        check("rst_5_0_en", 32'(got_en[5][5][0]), 32'(0));
        check("rst_5_4_en", 32'(got_en[5][5][4]), 32'(0));
        check("rst_5_6_en", 32'(got_en[5][5][6]), 32'(1));
        check("rst_5_6_pix", 32'(got_pix[5][5][6]), 32'h2323);
        check("rst_next_5_2_pix", 32'(got_pix[6][5][2]), 32'h2121);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
